prv32_ex_mem_reg: RTL
=====================

Name: prv32_ex_mem_reg

Overview:
- Pipeline boundary directly downstream of the ALU, between execute and memory.
- Captures ALU result, flags and execute-stage control into a single-entry valid/ready register.
- Resolves conditional branches and jumps from the ALU flags, and issues a one-cycle registered PC redirect to fetch.
- Honours back-pressure from the memory stage and a pipeline flush.

Parameters:
- XLEN, 32, datapath width of result, store data and PC fields.
- RF_AW, 5, register-file address width for rd.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill the held entry and any accept in this cycle.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  block can accept this cycle.
- alu_r  in  XLEN  ALU result.
- cf, zf, vf, sf  in  1 each  ALU flags from a+~b+1 (subtract); cf=1 means a>=b unsigned.
- rs2_data  in  XLEN  store data.
- rd  in  RF_AW  destination register.
- ctl_regwrite, ctl_memread, ctl_memwrite, ctl_memtoreg, ctl_branch, ctl_jump  in  1 each  decoded control.
- funct3  in  3  branch condition / memory size.
- br_target  in  XLEN  computed branch/jump target.
- pc_plus4  in  XLEN  link value.
- out_valid  out  1  memory stage entry valid.
- out_ready  in  1  memory stage consumes the entry this cycle.
- m_alu_r, m_store_data, m_pc_plus4  out  XLEN  registered copies.
- m_rd  out  RF_AW; m_funct3  out  3; m_regwrite, m_memread, m_memwrite, m_memtoreg  out  1 each.
- redirect_valid  out  1  one-cycle pulse: fetch must jump.
- redirect_pc  out  XLEN  target for redirect.

Behaviour:
- Reset (async): out_valid=0, redirect_valid=0, all m_* fields, m_* controls and redirect_pc = 0.
- in_ready = ~out_valid | out_ready. Combinational, with no dependence on in_valid.
- accept = in_valid & in_ready & ~flush.
  - On accept, every m_* field loads from its input and out_valid becomes 1.
  - If ~accept and out_ready, out_valid becomes 0.
  - Otherwise all held state stays unchanged (stall).
- Latency: 1 cycle from accept to out_valid.
- Flush has priority: out_valid becomes 0 and redirect_valid becomes 0 on that edge, regardless of in_valid or out_ready.
- While out_valid=0, m_* fields hold their last value. The memory stage ignores them.
- Flushed or bubbled entries keep m_regwrite and m_memwrite as loaded. The consumer qualifies them with out_valid.
- Branch condition, evaluated on inputs, by funct3:
  - 000 BEQ: zf
  - 001 BNE: ~zf
  - 100 BLT: sf^vf
  - 101 BGE: ~(sf^vf)
  - 110 BLTU: ~cf
  - 111 BGEU: cf
  - 010 and 011: not taken.
- taken = ctl_jump | (ctl_branch & cond).
- On accept with taken: next cycle redirect_valid=1 and redirect_pc=br_target.
- redirect_valid is 0 in every other cycle. It is never held during a stall.
- Simultaneous accept and flush: flush wins, with no capture and no redirect.
- The upstream controller flushes younger stages on redirect_valid. This block does not self-flush.

Test Plan:
- Reset mid-stall (out_valid=1, out_ready=0), assert rst -> out_valid=0, redirect_valid=0, m_alu_r=0 immediately, without waiting for a clock edge.
- Stream 3 ALU ops (alu_r=0x10, 0x20, 0x30) with out_ready=1 every cycle -> m_alu_r sequence 0x10, 0x20, 0x30 one cycle later; in_ready stays 1.
- out_ready=0 with entry held (alu_r=0xA5), in_valid=1 with 0x5A -> in_ready=0, m_alu_r stays 0xA5. Raise out_ready -> 0x5A captured next edge.
- Branch cases, each with ctl_branch=1 and br_target=0x100:
  - BEQ with zf=1 -> redirect_valid pulse for one cycle, redirect_pc=0x100.
  - BLTU with cf=1 -> no pulse.
  - BGE with sf=1, vf=1 -> pulse.
- ctl_jump=1, funct3=010, br_target=0x200 -> pulse, redirect_pc=0x200. ctl_branch=1, funct3=011 -> no pulse.
- in_valid=1, flush=1, taken branch in the same cycle -> out_valid=0 and redirect_valid=0 next cycle. Held entry with out_ready=0 plus flush -> out_valid=0.

Source files
------------

// File: rtl/prv32_ex_mem_reg.sv
// Execute/memory pipeline register: single-entry valid/ready stage that also
// resolves branches and jumps and issues a one-cycle registered PC redirect.
module prv32_ex_mem_reg #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  alu_r,
    input  logic             cf,
    input  logic             zf,
    input  logic             vf,
    input  logic             sf,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [RF_AW-1:0] rd,
    input  logic             ctl_regwrite,
    input  logic             ctl_memread,
    input  logic             ctl_memwrite,
    input  logic             ctl_memtoreg,
    input  logic             ctl_branch,
    input  logic             ctl_jump,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  br_target,
    input  logic [XLEN-1:0]  pc_plus4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  m_alu_r,
    output logic [XLEN-1:0]  m_store_data,
    output logic [XLEN-1:0]  m_pc_plus4,
    output logic [RF_AW-1:0] m_rd,
    output logic [2:0]       m_funct3,
    output logic             m_regwrite,
    output logic             m_memread,
    output logic             m_memwrite,
    output logic             m_memtoreg,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc
);

    logic accept;
    logic cond;
    logic taken;

    // Ready depends only on the held entry, so upstream never sees a loop through in_valid.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign taken    = ctl_jump | (ctl_branch & cond);

    // Flags come from a - b: signed less-than is sf^vf, unsigned a>=b is cf.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = zf;
            3'b001:  cond = ~zf;
            3'b100:  cond = sf ^ vf;
            3'b101:  cond = ~(sf ^ vf);
            3'b110:  cond = ~cf;
            3'b111:  cond = cf;
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only moves on accept; bubbles keep stale values that the consumer qualifies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_alu_r      <= '0;
            m_store_data <= '0;
            m_pc_plus4   <= '0;
            m_rd         <= '0;
            m_funct3     <= '0;
            m_regwrite   <= 1'b0;
            m_memread    <= 1'b0;
            m_memwrite   <= 1'b0;
            m_memtoreg   <= 1'b0;
        end else if (accept) begin
            m_alu_r      <= alu_r;
            m_store_data <= rs2_data;
            m_pc_plus4   <= pc_plus4;
            m_rd         <= rd;
            m_funct3     <= funct3;
            m_regwrite   <= ctl_regwrite;
            m_memread    <= ctl_memread;
            m_memwrite   <= ctl_memwrite;
            m_memtoreg   <= ctl_memtoreg;
        end
    end

    // Redirect is a pulse: accept is already masked by flush, so a flush edge clears it too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & taken;
            if (accept & taken) begin
                redirect_pc <= br_target;
            end
        end
    end

endmodule
